// File: rtl/count_sequence_checker.sv
// Sequence monitor for up/down/reverse counters: classifies each enabled sample
// against the previous one, tracks lock and direction, and counts illegal steps.
module count_sequence_checker #(
  parameter int MAX        = 16,
  parameter int WIDTH      = 4,
  parameter int LOCK_LEN   = 4,
  parameter int ALLOW_HOLD = 0,
  parameter int ERR_W      = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] count,
  output logic             locked,
  output logic             dir_up,
  output logic             step_ok,
  output logic             wrap,
  output logic             turn,
  output logic             error,
  output logic [ERR_W-1:0] error_count
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACQUIRE,
    ST_LOCKED
  } state_t;

  localparam int               RUN_W    = 8;
  localparam logic [WIDTH-1:0] LAST     = WIDTH'(MAX - 1);
  localparam logic [WIDTH:0]   MAX_W    = (WIDTH + 1)'(MAX);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_LEN);
  localparam bit               HOLD_OK  = (ALLOW_HOLD != 0);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             has_dir_q, has_dir_d;
  logic             dir_up_q, dir_up_d;
  logic             locked_q, locked_d;
  logic             step_ok_q, step_ok_d;
  logic             wrap_q, wrap_d;
  logic             turn_q, turn_d;
  logic             error_q, error_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             in_range;
  logic             up_raw, down_raw;
  logic             step_up, step_down, step_hold, step_legal;
  logic             step_wrap, step_turn;
  logic [RUN_W-1:0] run_inc;

  // Step classification of the current sample against the stored previous value
  always_comb begin
    in_range   = ({1'b0, count} < MAX_W);
    up_raw     = (prev_q == LAST) ? (count == '0) : (count == prev_q + WIDTH'(1));
    down_raw   = (prev_q == '0) ? (count == LAST) : (count == prev_q - WIDTH'(1));
    step_up    = in_range && up_raw;
    // For MAX = 2 both directions match; up takes precedence.
    step_down  = in_range && !step_up && down_raw;
    step_hold  = HOLD_OK && in_range && (count == prev_q);
    step_legal = step_up || step_down || step_hold;
    step_wrap  = (step_up && (count == '0)) || (step_down && (count == LAST));
    step_turn  = (step_up || step_down) && has_dir_q && (step_up != dir_up_q);
    run_inc    = run_q + RUN_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    run_d     = run_q;
    has_dir_d = has_dir_q;
    dir_up_d  = dir_up_q;
    locked_d  = locked_q;
    step_ok_d = 1'b0;
    wrap_d    = 1'b0;
    turn_d    = 1'b0;
    error_d   = 1'b0;
    err_cnt_d = err_cnt_q;

    if (enable) begin
      prev_d = count;
      unique case (state_q)
        ST_EMPTY: begin
          if (!in_range) begin
            error_d = 1'b1;
          end else begin
            state_d   = ST_ACQUIRE;
            run_d     = '0;
            has_dir_d = 1'b0;
          end
        end
        ST_ACQUIRE, ST_LOCKED: begin
          if (step_legal) begin
            step_ok_d = 1'b1;
            wrap_d    = step_wrap;
            turn_d    = step_turn;
            if (!step_hold) begin
              dir_up_d  = step_up;
              has_dir_d = 1'b1;
            end
            if (state_q == ST_ACQUIRE) begin
              run_d = run_inc;
              if (run_inc >= LOCK_RUN) begin
                state_d  = ST_LOCKED;
                locked_d = 1'b1;
              end
            end
          end else begin
            // Re-sync on the offending value; an out-of-range value cannot seed tracking.
            error_d  = 1'b1;
            run_d    = '0;
            locked_d = 1'b0;
            state_d  = in_range ? ST_ACQUIRE : ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
      if (error_d) err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_EMPTY;
      prev_q    <= '0;
      run_q     <= '0;
      has_dir_q <= 1'b0;
      dir_up_q  <= 1'b1;
      locked_q  <= 1'b0;
      step_ok_q <= 1'b0;
      wrap_q    <= 1'b0;
      turn_q    <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      run_q     <= run_d;
      has_dir_q <= has_dir_d;
      dir_up_q  <= dir_up_d;
      locked_q  <= locked_d;
      step_ok_q <= step_ok_d;
      wrap_q    <= wrap_d;
      turn_q    <= turn_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign locked      = locked_q;
  assign dir_up      = dir_up_q;
  assign step_ok     = step_ok_q;
  assign wrap        = wrap_q;
  assign turn        = turn_q;
  assign error       = error_q;
  assign error_count = err_cnt_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Bench for count_sequence_checker: three parameterisations share one stimulus
// stream and are compared against a per-instance rule-level reference model.
module tb_count_sequence_checker;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b0;
  logic [3:0] count   = 4'd0;
  logic [2:0] lk, du, ok, wr, tn, er;
  logic [7:0] ec0, ec1;
  logic [3:0] ec2;

  int nvec = 0;
  int nmis = 0;

  always #5 clock = ~clock;

  count_sequence_checker #(.MAX(16), .WIDTH(4), .LOCK_LEN(4), .ALLOW_HOLD(0), .ERR_W(8)) u0 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .count(count),
    .locked(lk[0]), .dir_up(du[0]), .step_ok(ok[0]), .wrap(wr[0]), .turn(tn[0]),
    .error(er[0]), .error_count(ec0));

  count_sequence_checker #(.MAX(16), .WIDTH(4), .LOCK_LEN(4), .ALLOW_HOLD(1), .ERR_W(8)) u1 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .count(count),
    .locked(lk[1]), .dir_up(du[1]), .step_ok(ok[1]), .wrap(wr[1]), .turn(tn[1]),
    .error(er[1]), .error_count(ec1));

  count_sequence_checker #(.MAX(10), .WIDTH(4), .LOCK_LEN(2), .ALLOW_HOLD(0), .ERR_W(4)) u2 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .count(count),
    .locked(lk[2]), .dir_up(du[2]), .step_ok(ok[2]), .wrap(wr[2]), .turn(tn[2]),
    .error(er[2]), .error_count(ec2));

  // Reference model: tracking is "have a previous value + length of the current legal run"
  typedef struct {
    bit locked, dir_up, step_ok, wrap, turn, error;
    int errs;
  } exp_t;

  int   m_max [3] = '{16, 16, 10};
  int   m_ll  [3] = '{4, 4, 2};
  bit   m_ah  [3] = '{0, 1, 0};
  int   m_emax[3] = '{255, 255, 15};
  bit   have_p[3];
  int   p[3], run[3], errs[3];
  bit   dir[3], has_dir[3];
  exp_t e[3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      have_p[k] = 0; p[k] = 0; run[k] = 0; errs[k] = 0;
      dir[k] = 1; has_dir[k] = 0;
      e[k].locked = 0; e[k].dir_up = 1; e[k].step_ok = 0; e[k].wrap = 0;
      e[k].turn = 0; e[k].error = 0; e[k].errs = 0;
    end
  endtask

  task automatic model_step(input int k, input bit en, input int s);
    int mx;
    bit up, dn, hd;
    mx = m_max[k];
    e[k].step_ok = 0; e[k].wrap = 0; e[k].turn = 0; e[k].error = 0;
    if (en) begin
      if (!have_p[k]) begin
        if (s >= mx) begin
          e[k].error = 1; errs[k]++;
        end else begin
          have_p[k] = 1; p[k] = s; run[k] = 0; has_dir[k] = 0;
        end
      end else begin
        up = (s < mx) && (s == (p[k] + 1) % mx);
        dn = (s < mx) && !up && (s == (p[k] + mx - 1) % mx);
        hd = (s < mx) && (s == p[k]) && m_ah[k];
        if (up || dn || hd) begin
          e[k].step_ok = 1;
          if (run[k] < 1000) run[k]++;
          if (up || dn) begin
            e[k].turn = has_dir[k] && (up != dir[k]);
            e[k].wrap = up ? (s == 0) : (s == mx - 1);
            dir[k] = up;
            has_dir[k] = 1;
          end
        end else begin
          e[k].error = 1; errs[k]++;
          run[k] = 0;
          if (s >= mx) have_p[k] = 0;
        end
        p[k] = s;
      end
      if (errs[k] > m_emax[k]) errs[k] = m_emax[k];
    end
    e[k].locked = have_p[k] && (run[k] >= m_ll[k]);
    e[k].dir_up = dir[k];
    e[k].errs   = errs[k];
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ec_of(input int k);
    if (k == 0) return int'(ec0);
    if (k == 1) return int'(ec1);
    return int'(ec2);
  endfunction

  task automatic check_dut(input int k, input string tag);
    cmp($sformatf("%s.u%0d.locked", tag, k),  int'(lk[k]), int'(e[k].locked));
    cmp($sformatf("%s.u%0d.dir_up", tag, k),  int'(du[k]), int'(e[k].dir_up));
    cmp($sformatf("%s.u%0d.step_ok", tag, k), int'(ok[k]), int'(e[k].step_ok));
    cmp($sformatf("%s.u%0d.wrap", tag, k),    int'(wr[k]), int'(e[k].wrap));
    cmp($sformatf("%s.u%0d.turn", tag, k),    int'(tn[k]), int'(e[k].turn));
    cmp($sformatf("%s.u%0d.error", tag, k),   int'(er[k]), int'(e[k].error));
    cmp($sformatf("%s.u%0d.err_cnt", tag, k), ec_of(k),    e[k].errs);
  endtask

  // Called #1 after a rising edge; inputs settle well before the next edge.
  task automatic apply(input bit en, input int s, input string tag);
    enable = en;
    count  = 4'(s);
    @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      model_step(k, en, s);
      check_dut(k, tag);
    end
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) check_dut(k, tag);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit rst, en;
    int s;
    bit lk, du, ok, wr, tn, er;
    int ec;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit rst, input bit en, input int s, input bit l, input bit d,
                              input bit o, input bit w, input bit t, input bit x, input int c);
    vec_t v;
    v.rst = rst; v.en = en; v.s = s;
    v.lk = l; v.du = d; v.ok = o; v.wr = w; v.tn = t; v.er = x; v.ec = c;
    tbl.push_back(v);
  endfunction

  initial begin
    int last;
    int r;
    int s;

    // Up run 0..15,0,1: lock after 5th sample, wrap on 15->0
    add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i < 16; i++) add(0, 1, i, i >= 4, 1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 1, 0, 0, 0);
    add(0, 1, 1, 1, 1, 1, 0, 0, 0, 0);
    // Down run 3,2,1,0,15,14 from reset: no turn, wrap on 0->15
    add(1, 1, 3, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 2, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 15, 1, 0, 1, 1, 0, 0, 0);
    add(0, 1, 14, 1, 0, 1, 0, 0, 0, 0);
    // Reversals while locked
    add(0, 1, 13, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 14, 1, 1, 1, 0, 1, 0, 0);
    add(0, 1, 15, 1, 1, 1, 0, 0, 0, 0);
    add(0, 1, 14, 1, 0, 1, 0, 1, 0, 0);
    add(0, 1, 13, 1, 0, 1, 0, 0, 0, 0);
    // Jump 7->9 while locked, then relock from 9
    add(1, 1, 3, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 4, 0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 5, 0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 6, 0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 7, 1, 1, 1, 0, 0, 0, 0);
    add(0, 1, 9, 0, 1, 0, 0, 0, 1, 1);
    add(0, 1, 10, 0, 1, 1, 0, 0, 0, 1);
    add(0, 1, 11, 0, 1, 1, 0, 0, 0, 1);
    add(0, 1, 12, 0, 1, 1, 0, 0, 0, 1);
    add(0, 1, 13, 1, 1, 1, 0, 0, 0, 1);
    // Repeat is an error without hold; enable gap keeps the stored value
    add(1, 1, 5, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 5, 0, 1, 0, 0, 0, 1, 1);
    add(0, 1, 6, 0, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 12, 0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 7, 0, 1, 1, 0, 0, 0, 1);
    add(0, 1, 8, 0, 1, 1, 0, 0, 0, 1);
    add(0, 1, 9, 1, 1, 1, 0, 0, 0, 1);

    model_reset();
    @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) check_dut(k, "reset");
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset($sformatf("tbl%0d.rst", i));
      apply(tbl[i].en, tbl[i].s, $sformatf("tbl%0d", i));
      cmp($sformatf("tbl%0d.locked", i),  int'(lk[0]), int'(tbl[i].lk));
      cmp($sformatf("tbl%0d.dir_up", i),  int'(du[0]), int'(tbl[i].du));
      cmp($sformatf("tbl%0d.step_ok", i), int'(ok[0]), int'(tbl[i].ok));
      cmp($sformatf("tbl%0d.wrap", i),    int'(wr[0]), int'(tbl[i].wr));
      cmp($sformatf("tbl%0d.turn", i),    int'(tn[0]), int'(tbl[i].tn));
      cmp($sformatf("tbl%0d.error", i),   int'(er[0]), int'(tbl[i].er));
      cmp($sformatf("tbl%0d.err_cnt", i), int'(ec0),   tbl[i].ec);
    end

    // Hold accepted only by the ALLOW_HOLD instance
    do_reset("hold.rst");
    apply(1, 5, "hold.a");
    apply(1, 5, "hold.b");
    cmp("hold.u1.step_ok", int'(ok[1]), 1);
    cmp("hold.u1.error",   int'(er[1]), 0);
    cmp("hold.u1.turnwrap", int'(tn[1]) + int'(wr[1]), 0);
    cmp("hold.u0.error",   int'(er[0]), 1);
    apply(1, 6, "hold.c");
    cmp("hold.u1.step_ok6", int'(ok[1]), 1);
    cmp("hold.u1.turn6",    int'(tn[1]), 0);

    // Out-of-range samples on the MAX=10 instance
    do_reset("range.rst");
    apply(1, 12, "range.a");
    cmp("range.u2.error", int'(er[2]), 1);
    cmp("range.u2.cnt",   int'(ec2), 1);
    apply(1, 3, "range.b");
    cmp("range.u2.first", int'(ok[2]) + int'(er[2]), 0);
    apply(1, 4, "range.c");
    cmp("range.u2.step_ok", int'(ok[2]), 1);

    // Error counter saturation
    do_reset("sat.rst");
    for (int i = 0; i < 300; i++) apply(1, (i % 2) ? 8 : 0, "sat");
    cmp("sat.u0.err_cnt", int'(ec0), 255);
    cmp("sat.u2.err_cnt", int'(ec2), 15);
    // Asynchronous clear mid-run, sampled before any edge
    reset_n = 1'b0;
    #1;
    cmp("async.u0.err_cnt", int'(ec0), 0);
    cmp("async.u0.dir_up",  int'(du[0]), 1);
    cmp("async.u0.error",   int'(er[0]), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();

    // Randomised run, biased toward legal neighbours so locks actually form
    last = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset("rnd.rst");
      r = $urandom_range(0, 9);
      if (r < 4)      s = (last + 1) % 16;
      else if (r < 7) s = (last + 15) % 16;
      else if (r < 8) s = last;
      else            s = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) begin
        apply(0, s, "rnd");
      end else begin
        apply(1, s, "rnd");
        last = s;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/count_sequence_checker.md
Name: count_sequence_checker

Overview:
- Receive-side monitor for the up/down/reverse counter family: samples a counter's output bus every enabled clock, classifies each step, recovers the counting direction, and flags illegal sequences.
- Sits beside any counter instance in benches and on-chip self-test.
- Reports lock status, direction, wrap and turnaround events, and a saturating error count.

Parameters:
- MAX, 16, number of legal counter states; legal values 0..MAX-1; MAX >= 2.
- WIDTH, 4, width of the sampled count bus; must satisfy 2^WIDTH >= MAX.
- LOCK_LEN, 4, consecutive legal steps required to declare lock; range 1..255.
- ALLOW_HOLD, 0, 1 = a repeated value is a legal "hold" step; 0 = a repeated value is an error.
- ERR_W, 8, width of the error counter.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  sample qualifier; count is sampled only when 1.
- count  in  WIDTH  counter value under check.
- locked  out  1  level; sequence is tracked.
- dir_up  out  1  last non-hold step direction: 1 = up, 0 = down.
- step_ok  out  1  one-cycle pulse; the last sample was a legal step.
- wrap  out  1  one-cycle pulse; legal wrap step MAX-1->0 (up) or 0->MAX-1 (down).
- turn  out  1  one-cycle pulse; legal step whose direction differs from the previous non-hold step.
- error  out  1  one-cycle pulse; illegal sample.
- error_count  out  ERR_W  saturating count of error pulses.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - State = EMPTY.
  - locked = 0, dir_up = 1, and all pulses = 0.
  - error_count = 0, and the stored previous value = 0.
- All outputs are registered. The response to the sample taken on edge N appears after edge N. Latency = 1 clock.
- When enable = 0:
  - Nothing is sampled.
  - All pulses are 0 on the next cycle.
  - State, previous value, run length and counters hold.
- Step classification of the sample s against the previous value p:
  - up: s == p+1, or p == MAX-1 and s == 0.
  - down: s == p-1, or p == 0 and s == MAX-1.
  - hold: s == p; legal only if ALLOW_HOLD = 1.
  - Any s >= MAX is illegal regardless of p.
  - Everything else is illegal.
  - For MAX = 2, up and down coincide; classify as up.
- State machine:
  - EMPTY: the first enabled sample is stored as p and produces no pulse. If s >= MAX, error pulses and the state stays EMPTY. Otherwise go to ACQUIRE with run = 0.
  - ACQUIRE: a legal step increments run, pulses step_ok, updates dir_up (except on hold) and stores p = s. When run reaches LOCK_LEN, go to LOCKED; locked rises in that same output cycle. An illegal step pulses error, sets run = 0 and stores p = s (re-sync on the bad value; if s >= MAX, go to EMPTY).
  - LOCKED: a legal step pulses step_ok plus wrap/turn as applicable. An illegal step pulses error, clears locked in the same output cycle, and goes to ACQUIRE with run = 0 and p = s (EMPTY if s >= MAX).
- turn and wrap are evaluated in ACQUIRE and LOCKED; turn requires a prior non-hold step since leaving EMPTY.
- A hold never sets turn or wrap and never changes dir_up.
- error_count increments on every error pulse and saturates at 2^ERR_W-1 (no wrap).
- Reset mid-run returns immediately to the reset values; the first sample after release is treated as EMPTY.

Test Plan:
- MAX = 16, LOCK_LEN = 4, enable = 1: feed 0,1,2,...,15,0,1 -> step_ok from the 2nd sample; locked = 1 after the 5th sample; wrap pulse exactly once, on 15->0; dir_up = 1; error_count = 0.
- Down count 3,2,1,0,15,14 -> dir_up = 0; wrap on 0->15; locked after 15; no turn.
- Reverse 13,14,15,14,13 -> turn pulse once, on 15->14; dir_up falls on that step; locked stays 1.
- While locked, inject 7 then 9 in an up run -> error pulse; locked = 0 in the same cycle; error_count = 1; relock after 4 further legal steps from 9.
- ALLOW_HOLD = 0 then 1, sequence 5,5,6 -> error on the repeat versus step_ok with no turn/wrap; toggling enable low for 3 cycles mid-run produces no pulses, and tracking resumes from the held p.
- Drive 300 illegal samples with ERR_W = 8 -> error_count saturates at 255; asserting reset_n = 0 mid-run clears all outputs asynchronously.
